key_debouncer: RTL
==================

KEY_DEBOUNCER -- requirements
Module: key_debouncer

Interface
REQ-001 Parameter STABLE_COUNT, default 1000000, consecutive stable cycles needed to accept a key change (20 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter LONG_COUNT, default 50000000, held-pressed cycles before long_press asserts (1 s at 50 MHz); legal range > STABLE_COUNT.
REQ-003 CLK  input  1  system clock, 50 MHz board clock; all logic on the rising edge.
REQ-004 CLR  input  1  reset, synchronous and active-low.
REQ-005 key_n  input  1  raw asynchronous push-button (KEYx); 0 = pressed.
REQ-006 level  output  1  debounced key state; 1 = pressed.
REQ-007 press_pulse  output  1  one-cycle strobe on accepted press; usable as a counter enable or clock for the downstream counter.
REQ-008 release_pulse  output  1  one-cycle strobe on accepted release.
REQ-009 long_press  output  1  present only with KEY_DEBOUNCER_LONGPRESS_EN (see Configuration).

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer before any other use; the FSM sees only the synchronized value (key_s).
REQ-011 FSM states SHALL be RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-012 RELEASED -> PRESS_WAIT when key_s = 0; PRESSED -> RELEASE_WAIT when key_s = 1; the stable counter is cleared on entry to either WAIT state.
REQ-013 In PRESS_WAIT, the counter increments on each cycle with key_s = 0; key_s = 1 returns to RELEASED with no output change (glitch rejected).
REQ-014 In RELEASE_WAIT, the counter increments on each cycle with key_s = 1; key_s = 0 returns to PRESSED with no output change.
REQ-015 With the counter at STABLE_COUNT-1 and key_s still matching, the FSM moves to PRESSED (or RELEASED) on that edge.
REQ-016 level, press_pulse and release_pulse SHALL be registered outputs.
REQ-017 level SHALL be 1 exactly when the state is PRESSED or RELEASE_WAIT.
REQ-018 press_pulse SHALL be high for exactly the one cycle on which level first reads 1.
REQ-019 release_pulse SHALL be high for exactly the one cycle on which level first reads 0.
REQ-020 Latency: when key_n is first sampled low at edge 1 and stays low, level rises after edge STABLE_COUNT+3; release latency is identical.
REQ-021 The stable counter width SHALL be $clog2(STABLE_COUNT) bits; it SHALL never wrap, because it is bounded by REQ-015.
REQ-022 press_pulse and release_pulse SHALL never be high in the same cycle; at most one pulse is issued per accepted edge.

Reset
REQ-023 When CLR = 0 at a rising edge: synchronizer flops <= 1 (released); state <= RELEASED; counters <= 0; level, press_pulse, release_pulse and long_press <= 0.
REQ-024 Reset mid-operation SHALL abandon any WAIT state without emitting a pulse.
REQ-025 A key still held after CLR deasserts SHALL be reported as a fresh press with full REQ-020 latency.

Configuration
REQ-026 With KEY_DEBOUNCER_LONGPRESS_EN defined: a hold counter of $clog2(LONG_COUNT+1) bits clears on entry to PRESSED, increments while in PRESSED or RELEASE_WAIT, and saturates at LONG_COUNT.
REQ-027 With the macro defined, long_press SHALL be 1 while hold counter = LONG_COUNT and level = 1, and SHALL clear on the cycle level falls.
REQ-028 Without the macro, the long_press port, the hold counter and the LONG_COUNT logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 Package key_debouncer_pkg SHALL hold the state enum typedef (2-bit) and the default constants DEBOUNCE_20MS = 1000000 and HOLD_1S = 50000000.
REQ-030 The synchronizer SHALL be sub-module sync_2ff (parameterized reset value), instantiated once.

Verification (STABLE_COUNT = 4, LONG_COUNT = 10)
REQ-031 key_n 1->0 at edge 1, held low -> level = 1 and press_pulse = 1 after edge 7; press_pulse = 0 after edge 8.
REQ-032 key_n low for 3 cycles, then high -> level, press_pulse and release_pulse stay 0 throughout.
REQ-033 Pressed, then key_n toggles 1/0/1/0 each cycle for 8 cycles and then stays high -> exactly one release_pulse, 7 edges after the final rise.
REQ-034 CLR = 0 asserted mid-PRESS_WAIT while key held, deasserted after 2 cycles -> no pulse during reset; press_pulse occurs STABLE_COUNT+3 edges after CLR release.
REQ-035 (macro defined) Hold key -> long_press = 1 at 10 cycles after level rises; release -> long_press = 0 on the same cycle level falls.
REQ-036 (macro undefined) Elaboration has no long_press port; REQ-031 to REQ-034 pass unchanged.

Source files
------------

// File: rtl/key_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: state encoding and board-rate defaults.
package key_debouncer_pkg;

  localparam int DEBOUNCE_20MS = 1000000;
  localparam int HOLD_1S       = 50000000;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_PRESSED      = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit, with a selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rstN,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debouncer.sv
// Push-button debouncer with registered level and press/release strobes.
// Define KEY_DEBOUNCER_LONGPRESS_EN to add the long_press output and its hold counter.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int STABLE_COUNT = DEBOUNCE_20MS
`ifdef KEY_DEBOUNCER_LONGPRESS_EN
  ,
  parameter int LONG_COUNT   = HOLD_1S
`endif
) (
  input  logic CLK,
  input  logic CLR,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
`ifdef KEY_DEBOUNCER_LONGPRESS_EN
  ,
  output logic long_press
`endif
);

  localparam int CNT_W = $clog2(STABLE_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

  logic           w_keyS;
  state_t         r_state;
  state_t         w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  logic           r_level;
  logic           r_press;
  logic           r_release;
  logic           w_levelNext;

  // Resets to released so a key held through reset is seen as a fresh press.
  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .i_clk (CLK),
    .i_rstN(CLR),
    .i_d   (key_n),
    .o_q   (w_keyS)
  );

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      ST_RELEASED: begin
        if (!w_keyS) begin
          w_stateNext = ST_PRESS_WAIT;
          w_cntNext   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (w_keyS)                w_stateNext = ST_RELEASED;
        else if (r_cnt == CNT_LAST) w_stateNext = ST_PRESSED;
        else                       w_cntNext   = r_cnt + 1'b1;
      end
      ST_PRESSED: begin
        if (w_keyS) begin
          w_stateNext = ST_RELEASE_WAIT;
          w_cntNext   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (!w_keyS)               w_stateNext = ST_PRESSED;
        else if (r_cnt == CNT_LAST) w_stateNext = ST_RELEASED;
        else                       w_cntNext   = r_cnt + 1'b1;
      end
      default: begin
        w_stateNext = ST_RELEASED;
        w_cntNext   = '0;
      end
    endcase
  end

  assign w_levelNext = (w_stateNext == ST_PRESSED) || (w_stateNext == ST_RELEASE_WAIT);

  // Strobes are derived from the level edge so they line up with the level change.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_state   <= ST_RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_level   <= w_levelNext;
      r_press   <= w_levelNext & ~r_level;
      r_release <= ~w_levelNext & r_level;
    end
  end

  assign level         = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

`ifdef KEY_DEBOUNCER_LONGPRESS_EN
  localparam int HOLD_W = $clog2(LONG_COUNT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_COUNT);

  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_holdNext;
  logic              r_longPress;

  always_comb begin
    w_holdNext = r_hold;
    if ((w_stateNext == ST_PRESSED) && (r_state != ST_PRESSED))
      w_holdNext = '0;
    else if (((r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT)) && (r_hold != HOLD_MAX))
      w_holdNext = r_hold + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!CLR) begin
      r_hold      <= '0;
      r_longPress <= 1'b0;
    end else begin
      r_hold      <= w_holdNext;
      r_longPress <= (w_holdNext == HOLD_MAX) && w_levelNext;
    end
  end

  assign long_press = r_longPress;
`endif

endmodule
